mux4_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 4:1 mux datapath among four requesters (a,b,c,d).

---
 rtl/mux4_rr_arbiter_if.sv | 30 +++
 rtl/mux4_rr_arbiter.sv | 111 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of the four producer ports, the mux select/grant outputs and the
// single valid/ready output stream of the round-robin mux arbiter.
interface mux4_rr_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic [3:0]       req;
  logic [WIDTH-1:0] din_a;
  logic [WIDTH-1:0] din_b;
  logic [WIDTH-1:0] din_c;
  logic [WIDTH-1:0] din_d;
  logic [3:0]       gnt;
  logic             s1;
  logic             s2;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;

  // Arbiter side.
  modport master (
    input  req, din_a, din_b, din_c, din_d, dout_ready,
    output gnt, s1, s2, dout, dout_valid, busy
  );

  // Producers and consumer side.
  modport slave (
    output req, din_a, din_b, din_c, din_d, dout_ready,
    input  gnt, s1, s2, dout, dout_valid, busy
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among requesters a..d, with each
// grant bounded to MAX_HOLD transferred beats and one IDLE bubble between grants.
module mux4_rr_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  mux4_rr_arbiter_if.master   bus
);

  localparam int unsigned CNT_W = $clog2(MAX_HOLD) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       sel;
  logic [1:0]       sel_nxt;
  logic [1:0]       ptr;
  logic [1:0]       ptr_nxt;
  logic [3:0]       gnt;
  logic [3:0]       gnt_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_cnt_nxt;
  logic [1:0]       cand;
  logic             found;
  logic             xfer_c;

  // State and grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= 2'd0;
      ptr      <= 2'd0;
      gnt      <= 4'd0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      ptr      <= ptr_nxt;
      gnt      <= gnt_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  assign xfer_c = bus.dout_valid & bus.dout_ready;

  // Next-state: arbitrate in IDLE, count beats and decide release in GRANT.
  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    ptr_nxt      = ptr;
    gnt_nxt      = gnt;
    beat_cnt_nxt = beat_cnt;
    cand         = 2'd0;
    found        = 1'b0;
    unique case (state)
      IDLE: begin
        for (int i = 0; i < 4; i++) begin
          cand = ptr + 2'(i);
          if (!found && bus.req[cand]) begin
            found   = 1'b1;
            sel_nxt = cand;
          end
        end
        if (found) begin
          state_nxt    = GRANT;
          gnt_nxt      = 4'd1 << sel_nxt;
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        // A dropped request or the last allowed beat hands the mux on.
        if (!bus.req[sel] || (xfer_c && beat_cnt == CNT_W'(MAX_HOLD - 1))) begin
          state_nxt    = IDLE;
          gnt_nxt      = 4'd0;
          ptr_nxt      = sel + 2'd1;
          beat_cnt_nxt = '0;
        end else if (xfer_c) begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: registered selects/grant, muxed data and valid follow live inputs.
  always_comb begin
    bus.dout       = {WIDTH{1'b0}};
    bus.dout_valid = 1'b0;
    bus.busy       = (state == GRANT);
    if (state == GRANT) begin
      unique case (sel)
        2'd0:    bus.dout = bus.din_a;
        2'd1:    bus.dout = bus.din_b;
        2'd2:    bus.dout = bus.din_c;
        default: bus.dout = bus.din_d;
      endcase
      bus.dout_valid = bus.req[sel];
    end
  end

  assign bus.gnt = gnt;
  assign bus.s1  = sel[1];
  assign bus.s2  = sel[0];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed vector table, multi-cycle corner
// sequences, then randomized traffic against a transaction-level model.
module tb_mux4_rr_arbiter;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned MAX_HOLD = 4;

  logic clk;
  logic rst;

  mux4_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [7:0] dout;
    logic       valid;
    logic       busy;
  } vec_t;

  vec_t vecs[10];

  // Reference model: owner is the granted requester index or -1 when idle.
  int m_owner;
  int m_ptr;
  int m_beats;
  int m_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic [3:0] q, input logic rdy);
    rst            = r;
    bus.req        = q;
    bus.dout_ready = rdy;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] din_of(input int i);
    case (i)
      0:       return bus.din_a;
      1:       return bus.din_b;
      2:       return bus.din_c;
      default: return bus.din_d;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic [3:0] q, input logic rdy);
    if (r) begin
      m_owner = -1; m_ptr = 0; m_beats = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && q[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_sel   = m_owner;
          m_beats = 0;
        end
      end
    end else if (!q[m_owner]) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
    end else if (rdy) begin
      m_beats++;
      if (m_beats == MAX_HOLD) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_beats = 0;
      end
    end
  endtask

  task automatic model_check();
    logic [3:0] e_gnt;
    logic [7:0] e_dout;
    logic       e_valid;
    e_gnt   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    e_dout  = (m_owner >= 0) ? din_of(m_owner) : 8'd0;
    e_valid = (m_owner >= 0) && bus.req[m_owner];
    chk("rand_gnt",   32'(bus.gnt), 32'(e_gnt));
    chk("rand_sel",   32'({bus.s1, bus.s2}), 32'(m_sel));
    chk("rand_dout",  32'(bus.dout), 32'(e_dout));
    chk("rand_valid", 32'(bus.dout_valid), 32'(e_valid));
    chk("rand_busy",  32'(bus.busy), 32'(m_owner >= 0));
  endtask

  initial begin
    logic [3:0] prev_gnt;
    logic [3:0] order[$];
    int         runs[$];
    int         run_len;
    logic       r;
    logic [3:0] q;
    logic       rdy;

    // Reset with all requesting, then a sole requester c for two grants.
    vecs[0] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 8'hA5, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 8'hA5, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 8'hA5, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 8'hA5, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 8'hA5, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 4'b0000, 1'b1, 4'b0100, 2'd2, 8'hA5, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2, 8'h00, 1'b0, 1'b0};

    bus.din_a = 8'h11;
    bus.din_b = 8'h22;
    bus.din_c = 8'hA5;
    bus.din_d = 8'h44;
    apply(1'b1, 4'b1111, 1'b1);
    advance();

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].rst, vecs[i].req, vecs[i].rdy);
      chk("vec_gnt",   32'(bus.gnt), 32'(vecs[i].gnt));
      chk("vec_sel",   32'({bus.s1, bus.s2}), 32'(vecs[i].sel));
      chk("vec_dout",  32'(bus.dout), 32'(vecs[i].dout));
      chk("vec_valid", 32'(bus.dout_valid), 32'(vecs[i].valid));
      chk("vec_busy",  32'(bus.busy), 32'(vecs[i].busy));
      advance();
    end

    // Round robin with everyone requesting: a,b,c,d,a, four beats each.
    apply(1'b1, 4'b0000, 1'b1);
    advance();
    prev_gnt = 4'd0;
    run_len  = 0;
    for (int c = 0; c < 25; c++) begin
      apply(1'b0, 4'b1111, 1'b1);
      if (bus.gnt != 4'd0 && prev_gnt == 4'd0) order.push_back(bus.gnt);
      if (bus.gnt != 4'd0) run_len++;
      else if (prev_gnt != 4'd0) begin
        runs.push_back(run_len);
        run_len = 0;
      end
      prev_gnt = bus.gnt;
      advance();
    end
    chk("rr_grant_count", 32'(order.size()), 32'd5);
    chk("rr_run_count",   32'(runs.size()), 32'd4);
    for (int k = 0; k < 5 && k < order.size(); k++)
      chk("rr_order", 32'(order[k]), 32'(4'd1 << (k % 4)));
    for (int k = 0; k < runs.size(); k++)
      chk("rr_run_len", 32'(runs[k]), 32'(MAX_HOLD));

    // Early drop by b after two beats moves the pointer past b to d.
    apply(1'b1, 4'b0000, 1'b1);
    advance();
    apply(1'b0, 4'b0010, 1'b1); advance();
    apply(1'b0, 4'b0010, 1'b1);
    chk("drop_gnt_b", 32'(bus.gnt), 32'h2);
    advance();
    apply(1'b0, 4'b0010, 1'b1); advance();
    apply(1'b0, 4'b1001, 1'b1);
    chk("drop_valid", 32'(bus.dout_valid), 32'd0);
    chk("drop_gnt_hold", 32'(bus.gnt), 32'h2);
    advance();
    apply(1'b0, 4'b1001, 1'b1);
    chk("drop_idle", 32'(bus.gnt), 32'h0);
    advance();
    apply(1'b0, 4'b1001, 1'b1);
    chk("drop_gnt_d", 32'(bus.gnt), 32'h8);
    chk("drop_sel_d", 32'({bus.s1, bus.s2}), 32'd3);
    chk("drop_dout_d", 32'(bus.dout), 32'h44);
    advance();

    // Backpressure: ten stalled cycles hold the grant, then exactly four beats.
    apply(1'b1, 4'b0000, 1'b1);
    advance();
    apply(1'b0, 4'b0001, 1'b0); advance();
    for (int c = 0; c < 10; c++) begin
      apply(1'b0, 4'b0001, 1'b0);
      chk("bp_hold_gnt", 32'(bus.gnt), 32'h1);
      chk("bp_hold_valid", 32'(bus.dout_valid), 32'd1);
      advance();
    end
    for (int c = 0; c < 4; c++) begin
      apply(1'b0, 4'b0001, 1'b1);
      chk("bp_beat_gnt", 32'(bus.gnt), 32'h1);
      advance();
    end
    apply(1'b0, 4'b0001, 1'b1);
    chk("bp_release", 32'(bus.gnt), 32'h0);
    advance();

    // Reset during beat 2 of c clears the pointer left at c by b's release.
    apply(1'b1, 4'b0000, 1'b1);
    advance();
    apply(1'b0, 4'b0010, 1'b1); advance();
    apply(1'b0, 4'b0000, 1'b1); advance();
    apply(1'b0, 4'b0100, 1'b1); advance();
    apply(1'b0, 4'b0100, 1'b1);
    chk("mid_gnt_c", 32'(bus.gnt), 32'h4);
    advance();
    apply(1'b1, 4'b0100, 1'b1); advance();
    apply(1'b0, 4'b0101, 1'b1);
    chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    chk("mid_rst_sel", 32'({bus.s1, bus.s2}), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    advance();
    apply(1'b0, 4'b0101, 1'b1);
    chk("mid_gnt_a", 32'(bus.gnt), 32'h1);
    advance();

    // Randomized traffic against the reference model.
    apply(1'b1, 4'b0000, 1'b1);
    advance();
    model_step(1'b1, 4'b0000, 1'b1);
    q = 4'b0000;
    for (int c = 0; c < 1500; c++) begin
      r   = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) q = 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 3) != 0);
      bus.din_a = 8'($urandom);
      bus.din_b = 8'($urandom);
      bus.din_c = 8'($urandom);
      bus.din_d = 8'($urandom);
      apply(r, q, rdy);
      model_check();
      model_step(r, q, rdy);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
